// File: rtl/master_cpu_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : master_cpu_oci_dct_pkg
//  Description : Shared widths, sequencer state type and word-packing helper
//                for the OCI debug-capture-trace (DCT) buffer controller.
//  Revision    : 1.0  initial release
// ============================================================================
package master_cpu_oci_dct_pkg;

    localparam int FRAG_W = 2;               // bits per trace fragment
    localparam int NFRAG  = 15;              // fragments per packed word
    localparam int DCT_W  = FRAG_W * NFRAG;  // packing buffer width (30)
    localparam int CNT_W  = 4;               // fragment count field width
    localparam int TW_W   = CNT_W + DCT_W;   // trace-memory word width (34)

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STOP  = 2'd2,
        ST_ENDED = 2'd3
    } dct_state_e;

    // Trace-memory word layout: fragment count on top of the packed fragments.
    function automatic logic [TW_W-1:0] pack_word(input logic [CNT_W-1:0] cnt,
                                                  input logic [DCT_W-1:0] frags);
        return {cnt, frags};
    endfunction

endpackage : master_cpu_oci_dct_pkg
`default_nettype wire

// File: rtl/master_cpu_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
//  Module      : master_cpu_oci_dct_outreg
//  Description : One-entry valid/ready holding register for committed trace
//                words plus the trace-memory write address counter.
//  Revision    : 1.0  initial release
// ============================================================================
module master_cpu_oci_dct_outreg
    import master_cpu_oci_dct_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter bit WRAP   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [TW_W-1:0]   load_word,
    input  logic              tw_ready,
    output logic              tw_valid,
    output logic [TW_W-1:0]   tw_data,
    output logic [ADDR_W-1:0] tw_addr,
    output logic              can_load,
    output logic              last_hs
);

    localparam logic [ADDR_W-1:0] c_addr_max = '1;

    logic              r_valid;
    logic [TW_W-1:0]   r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              w_hs;

    assign w_hs     = r_valid & tw_ready;
    // A new word may enter when the slot is empty or is being drained this cycle.
    assign can_load = ~r_valid | w_hs;
    // Without wrap, the handshake at the top address is the final write.
    assign last_hs  = w_hs & ~WRAP & (r_addr == c_addr_max);

    assign tw_valid = r_valid;
    assign tw_data  = r_data;
    assign tw_addr  = r_addr;

    // Holding register and address counter; address advances once per handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
        end else begin
            if (load) begin
                r_valid <= 1'b1;
                r_data  <= load_word;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_hs && (WRAP || (r_addr != c_addr_max))) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

endmodule : master_cpu_oci_dct_outreg
`default_nettype wire

// File: rtl/master_cpu_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : master_cpu_oci_dct_ctrl
//  Description : DCT capture/drain sequencer. Packs trace fragments into the
//                30-bit dct_buffer, commits full or flushed words to the
//                output register, and runs the end-of-test flush.
//  Revision    : 1.0  initial release
// ============================================================================
module master_cpu_oci_dct_ctrl #(
    parameter int FRAG_W = 2,
    parameter int NFRAG  = 15,
    parameter int ADDR_W = 7,
    parameter bit WRAP   = 1'b1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      trc_on,
    input  logic                                      frag_valid,
    input  logic [FRAG_W-1:0]                         frag_data,
    input  logic                                      flush_req,
    input  logic                                      test_ending,
    input  logic                                      tw_ready,
    output logic                                      tw_valid,
    output logic [master_cpu_oci_dct_pkg::TW_W-1:0]   tw_data,
    output logic [ADDR_W-1:0]                         tw_addr,
    output logic [master_cpu_oci_dct_pkg::DCT_W-1:0]  dct_buffer,
    output logic [master_cpu_oci_dct_pkg::CNT_W-1:0]  dct_count,
    output logic                                      overflow,
    output logic                                      test_has_ended
);

    import master_cpu_oci_dct_pkg::*;

    localparam logic [CNT_W-1:0] c_nfrag = CNT_W'(NFRAG);

    dct_state_e       r_state, w_state_nxt;
    logic [DCT_W-1:0] r_buf, w_buf_nxt, w_fill_buf;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_fill_cnt;
    logic             r_pend, w_pend_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             w_acc, w_commit_en, w_flush, w_want;
    logic             w_load;
    logic [TW_W-1:0]  w_load_word;
    logic             w_can_load, w_last_hs;

    master_cpu_oci_dct_outreg #(
        .ADDR_W (ADDR_W),
        .WRAP   (WRAP)
    ) u_outreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (w_load),
        .load_word (w_load_word),
        .tw_ready  (tw_ready),
        .tw_valid  (tw_valid),
        .tw_data   (tw_data),
        .tw_addr   (tw_addr),
        .can_load  (w_can_load),
        .last_hs   (w_last_hs)
    );

    // Packing, commit decision, pending flush and overflow tracking.
    always_comb begin
        w_acc       = frag_valid & trc_on & (r_state == ST_RUN);
        w_commit_en = ((r_state == ST_RUN) | (r_state == ST_FLUSH)) & w_can_load;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_ovf_nxt   = r_ovf;
        w_fill_buf  = r_buf;
        w_fill_cnt  = r_cnt;
        w_flush     = 1'b0;
        w_want      = 1'b0;
        w_load      = 1'b0;
        w_load_word = pack_word(r_cnt, r_buf);

        if ((r_state == ST_STOP) && frag_valid && trc_on) begin
            w_ovf_nxt = 1'b1;
        end

        if (r_cnt == c_nfrag) begin
            // Full word waiting: drain it when possible and start a fresh word
            // with any fragment arriving now; otherwise that fragment is lost.
            if (w_commit_en) begin
                w_load     = 1'b1;
                w_buf_nxt  = '0;
                w_cnt_nxt  = '0;
                w_pend_nxt = 1'b0;
                if (w_acc) begin
                    w_buf_nxt[FRAG_W-1:0] = frag_data;
                    w_cnt_nxt             = CNT_W'(1);
                end
            end else if (w_acc) begin
                w_ovf_nxt = 1'b1;
            end
        end else begin
            for (int i = 0; i < NFRAG; i++) begin
                if (w_acc && (r_cnt == CNT_W'(i))) begin
                    w_fill_buf[i*FRAG_W +: FRAG_W] = frag_data;
                end
            end
            if (w_acc) begin
                w_fill_cnt = r_cnt + CNT_W'(1);
            end
            w_flush = flush_req | r_pend | (r_state == ST_FLUSH);
            w_want  = (w_fill_cnt == c_nfrag) | (w_flush & (w_fill_cnt != '0));
            if (w_want && w_commit_en) begin
                w_load      = 1'b1;
                w_load_word = pack_word(w_fill_cnt, w_fill_buf);
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end else begin
                w_buf_nxt  = w_fill_buf;
                w_cnt_nxt  = w_fill_cnt;
                // A flush that cannot commit yet is remembered; empty flushes vanish.
                w_pend_nxt = (flush_req | r_pend) & (w_fill_cnt != '0);
            end
        end
    end

    // Sequencer next state: drain on test end, park after the final address.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_last_hs) begin
                    w_state_nxt = ST_STOP;
                end else if (test_ending) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((w_cnt_nxt == '0) && !w_load && (!tw_valid || tw_ready)) begin
                    w_state_nxt = ST_ENDED;
                end
            end
            ST_STOP: begin
                if (test_ending) begin
                    w_state_nxt = ST_ENDED;
                end
            end
            ST_ENDED: w_state_nxt = ST_ENDED;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packing buffer, fragment count and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_cnt  <= w_cnt_nxt;
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign dct_buffer     = r_buf;
    assign dct_count      = r_cnt;
    assign overflow       = r_ovf;
    assign test_has_ended = (r_state == ST_ENDED);

endmodule : master_cpu_oci_dct_ctrl
`default_nettype wire
